// File: rtl/shmcp_n.sv
// ---------------------------------------------------------------------------
// shmcp_n : small stored-program accumulator machine.
//
// The program memory is filled in load mode (state=0), one word per load
// strobe, in address order starting at 0. Once all 2^AW slots are written,
// prog_full is set and stays set. Further load strobes are then ignored.
// In run mode (state=1) the core starts at pc=0. Each instruction takes three
// cycles: FETCH, DECODE and EXEC. The core stops in HALT until state returns
// to 0. Dropping state during FETCH, DECODE or EXEC abandons the current
// instruction. The A, B and R registers and the flags are kept.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset (also clears program memory)
//   state      0 = load mode, 1 = run mode
//   load       program-write strobe, honoured only when state=0
//   instr      instruction word to write, {opcode[3:0], operand[DW-1:0]}
//   pc         current program counter
//   acc        ALU result register R
//   out_data   R captured by the most recent OUT instruction
//   out_valid  one-cycle pulse when out_data updates
//   zf, cf     zero flag, carry/borrow flag
//   busy       high in FETCH, DECODE and EXEC
//   halted     high in HALT
//   prog_full  all program slots have been written
// ---------------------------------------------------------------------------
module shmcp_n #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            state,
   input  logic            load,
   input  logic [DW+3:0]   instr,
   output logic [AW-1:0]   pc,
   output logic [DW-1:0]   acc,
   output logic [DW-1:0]   out_data,
   output logic            out_valid,
   output logic            zf,
   output logic            cf,
   output logic            busy,
   output logic            halted,
   output logic            prog_full
);

   localparam int          IW     = DW + 4;
   localparam int unsigned DEPTH  = 2 ** AW;
   localparam logic [AW-1:0] AW_ONE = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT
   } fsm_e;

   typedef enum logic [3:0] {
      OP_SYS = 4'h0,
      OP_LDA = 4'h1,
      OP_LDB = 4'h2,
      OP_JMP = 4'h3,
      OP_JNZ = 4'h4,
      OP_JZ  = 4'h5,
      OP_JC  = 4'h6
   } op_e;

   typedef enum logic [3:0] {
      SUB_NOP  = 4'h0,
      SUB_ADD  = 4'h1,
      SUB_SUB  = 4'h2,
      SUB_AND  = 4'h3,
      SUB_OR   = 4'h4,
      SUB_XOR  = 4'h5,
      SUB_A_R  = 4'h6,
      SUB_B_R  = 4'h7,
      SUB_OUT  = 4'h8,
      SUB_HALT = 4'hF
   } sub_e;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   fsm_e            fsm_q;
   logic [IW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   load_addr_q;
   logic            prog_full_q;
   logic [IW-1:0]   ir_q;
   logic [AW-1:0]   pc_q;
   logic [DW-1:0]   a_q, b_q, r_q;
   logic            zf_q, cf_q;
   logic [DW-1:0]   out_data_q;
   logic            out_valid_q;
   logic            busy_q, halted_q;

   // ---------------------------------------------------------------------
   // Execute-stage next values, derived from the instruction register
   // ---------------------------------------------------------------------
   logic [3:0]      opcode_w;
   logic [DW-1:0]   operand_w;
   logic [3:0]      subop_w;
   logic [AW-1:0]   target_w;
   logic [DW:0]     sum_w, diff_w;
   logic [DW-1:0]   a_d, b_d, r_d;
   logic            zf_d, cf_d;
   logic [AW-1:0]   pc_d;
   logic            flags_upd_w, out_fire_w, halt_fire_w;

   always_comb begin
      opcode_w  = ir_q[IW-1:IW-4];
      operand_w = ir_q[DW-1:0];
      subop_w   = operand_w[3:0];
      target_w  = operand_w[AW-1:0];

      // Both results use DW+1 bits. For the sum, the top bit is the carry out.
      // For the difference, the top bit is the borrow, which means A < B unsigned.
      sum_w  = {1'b0, a_q} + {1'b0, b_q};
      diff_w = {1'b0, a_q} - {1'b0, b_q};

      a_d         = a_q;
      b_d         = b_q;
      r_d         = r_q;
      zf_d        = zf_q;
      cf_d        = cf_q;
      pc_d        = pc_q + AW_ONE;
      flags_upd_w = 1'b0;
      out_fire_w  = 1'b0;
      halt_fire_w = 1'b0;

      case (opcode_w)
         OP_SYS: begin
            case (subop_w)
               SUB_ADD: begin
                  r_d         = sum_w[DW-1:0];
                  cf_d        = sum_w[DW];
                  flags_upd_w = 1'b1;
               end
               SUB_SUB: begin
                  r_d         = diff_w[DW-1:0];
                  cf_d        = diff_w[DW];
                  flags_upd_w = 1'b1;
               end
               SUB_AND: begin
                  r_d         = a_q & b_q;
                  cf_d        = 1'b0;
                  flags_upd_w = 1'b1;
               end
               SUB_OR: begin
                  r_d         = a_q | b_q;
                  cf_d        = 1'b0;
                  flags_upd_w = 1'b1;
               end
               SUB_XOR: begin
                  r_d         = a_q ^ b_q;
                  cf_d        = 1'b0;
                  flags_upd_w = 1'b1;
               end
               SUB_A_R:  a_d = r_q;
               SUB_B_R:  b_d = r_q;
               SUB_OUT:  out_fire_w = 1'b1;
               SUB_HALT: begin
                  halt_fire_w = 1'b1;
                  pc_d        = pc_q;
               end
               default: ;
            endcase
         end
         OP_LDA: a_d = operand_w;
         OP_LDB: b_d = operand_w;
         OP_JMP: pc_d = target_w;
         OP_JNZ: if (!zf_q) pc_d = target_w;
         OP_JZ:  if (zf_q)  pc_d = target_w;
         OP_JC:  if (cf_q)  pc_d = target_w;
         default: ;
      endcase

      if (flags_upd_w) zf_d = (r_d == '0);
   end

   // ---------------------------------------------------------------------
   // Sequencer, program loader and architectural registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm_q       <= S_IDLE;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         load_addr_q <= '0;
         prog_full_q <= 1'b0;
         ir_q        <= '0;
         pc_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         r_q         <= '0;
         zf_q        <= 1'b0;
         cf_q        <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;

         // The last slot sets prog_full and leaves load_addr where it is,
         // so later strobes cannot wrap around and overwrite slot 0.
         if (!state && load && !prog_full_q) begin
            mem_q[load_addr_q] <= instr;
            if (load_addr_q == '1) prog_full_q <= 1'b1;
            else                   load_addr_q <= load_addr_q + AW_ONE;
         end

         unique case (fsm_q)
            S_IDLE: begin
               if (state) begin
                  fsm_q  <= S_FETCH;
                  pc_q   <= '0;
                  busy_q <= 1'b1;
               end
            end
            S_FETCH: begin
               if (!state) begin
                  fsm_q  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  ir_q  <= mem_q[pc_q];
                  fsm_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!state) begin
                  fsm_q  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  fsm_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               // When the core aborts here, it skips the commit. This
               // leaves A, B, R, the flags and pc unchanged.
               if (!state) begin
                  fsm_q  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  a_q  <= a_d;
                  b_q  <= b_d;
                  r_q  <= r_d;
                  zf_q <= zf_d;
                  cf_q <= cf_d;
                  pc_q <= pc_d;
                  if (out_fire_w) begin
                     out_data_q  <= r_q;
                     out_valid_q <= 1'b1;
                  end
                  if (halt_fire_w) begin
                     fsm_q    <= S_HALT;
                     busy_q   <= 1'b0;
                     halted_q <= 1'b1;
                  end else begin
                     fsm_q <= S_FETCH;
                  end
               end
            end
            S_HALT: begin
               if (!state) begin
                  fsm_q    <= S_IDLE;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               fsm_q    <= S_IDLE;
               busy_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc        = pc_q;
   assign acc       = r_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign zf        = zf_q;
   assign cf        = cf_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign prog_full = prog_full_q;

endmodule

// File: tb/tb_shmcp_n.sv
// ---------------------------------------------------------------------------
// tb_shmcp_n : bench for shmcp_n with DW=8 and AW=4.
//
// A behavioural instruction-set model steps once per instruction. When it
// executes an OUT, it pushes the value it expects onto a scoreboard queue.
// An independent monitor pops from that queue on every out_valid pulse and
// compares. Architectural state is compared after each EXEC edge.
// ---------------------------------------------------------------------------
module tb_shmcp_n;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int IW    = DW + 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst, state, load;
   logic [IW-1:0] instr;
   logic [AW-1:0] pc;
   logic [DW-1:0] acc, out_data;
   logic          out_valid, zf, cf, busy, halted, prog_full;

   always #5 clk = ~clk;

   shmcp_n #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .state(state), .load(load), .instr(instr),
      .pc(pc), .acc(acc), .out_data(out_data), .out_valid(out_valid),
      .zf(zf), .cf(cf), .busy(busy), .halted(halted), .prog_full(prog_full)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int n_out  = 0;
   int exp_q[$];

   // Reference model state
   int mm[DEPTH];
   int m_laddr, m_full;
   int mA, mB, mR, mzf, mcf, mpc, mhalt;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst === 1'b1 && out_valid === 1'b1) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_extra_out: got out_data 0x%0h, expected no output", out_data);
         end else begin
            chk("sb_out_data", int'(out_data), exp_q.pop_front());
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) mm[i] = 0;
      m_laddr = 0; m_full = 0;
      mA = 0; mB = 0; mR = 0; mzf = 0; mcf = 0; mpc = 0; mhalt = 0;
   endtask

   task automatic m_load(input int w);
      if (!m_full) begin
         mm[m_laddr] = w;
         m_laddr++;
         if (m_laddr == DEPTH) m_full = 1;
      end
   endtask

   task automatic m_step();
      int w, op, opd, sub, nxt, s;
      w   = mm[mpc];
      op  = w / 256;
      opd = w % 256;
      sub = opd % 16;
      nxt = (mpc + 1) % DEPTH;
      case (op)
         0: case (sub)
            1: begin s = mA + mB; mR = s % 256; mcf = (s > 255); mzf = (mR == 0); end
            2: begin mR = (mA - mB + 256) % 256; mcf = (mA < mB); mzf = (mR == 0); end
            3: begin mR = mA & mB; mcf = 0; mzf = (mR == 0); end
            4: begin mR = mA | mB; mcf = 0; mzf = (mR == 0); end
            5: begin mR = mA ^ mB; mcf = 0; mzf = (mR == 0); end
            6: mA = mR;
            7: mB = mR;
            8: exp_q.push_back(mR);
            15: begin mhalt = 1; nxt = mpc; end
            default: ;
         endcase
         1: mA = opd;
         2: mB = opd;
         3: nxt = opd % DEPTH;
         4: if (mzf == 0) nxt = opd % DEPTH;
         5: if (mzf == 1) nxt = opd % DEPTH;
         6: if (mcf == 1) nxt = opd % DEPTH;
         default: ;
      endcase
      mpc = nxt;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic chk_reset_vals(input string p);
      chk({p, "_pc"}, int'(pc), 0);
      chk({p, "_acc"}, int'(acc), 0);
      chk({p, "_out_data"}, int'(out_data), 0);
      chk({p, "_out_valid"}, int'(out_valid), 0);
      chk({p, "_zf"}, int'(zf), 0);
      chk({p, "_cf"}, int'(cf), 0);
      chk({p, "_busy"}, int'(busy), 0);
      chk({p, "_halted"}, int'(halted), 0);
      chk({p, "_prog_full"}, int'(prog_full), 0);
   endtask

   task automatic do_reset();
      rst = 1'b0; state = 1'b0; load = 1'b0; instr = '0;
      tick();
      m_reset();
      chk_reset_vals("reset");
      rst = 1'b1;
   endtask

   task automatic do_load(input int w);
      state = 1'b0; load = 1'b1; instr = IW'(w);
      m_load(w);
      tick();
      load = 1'b0;
   endtask

   // Run from pc=0 for at most max_instr instructions or until HALT. If the
   // program has not halted, drop state abort_phase cycles into the next
   // instruction (0=FETCH, 1=DECODE, 2=EXEC). Return the cycle, counted from
   // the first FETCH, at which halted was first seen, or -1.
   task automatic run(input int max_instr, input int abort_phase, output int cyc_halt);
      int n, cyc;
      cyc_halt = -1;
      n = 0; cyc = 0;
      state = 1'b1;
      tick();
      chk("run_busy_start", int'(busy), 1);
      chk("run_pc_start", int'(pc), 0);
      mpc = 0;
      while (n < max_instr && mhalt == 0) begin
         m_step();
         n++;
         tick(); tick();
         chk("run_halted_exec", int'(halted), 0);
         chk("run_busy_exec", int'(busy), 1);
         tick();
         cyc += 3;
         if (halted === 1'b1 && cyc_halt < 0) cyc_halt = cyc;
         chk("run_pc", int'(pc), mpc);
         chk("run_acc", int'(acc), mR);
         chk("run_zf", int'(zf), mzf);
         chk("run_cf", int'(cf), mcf);
         chk("run_halted", int'(halted), mhalt);
         chk("run_busy", int'(busy), (mhalt == 0) ? 1 : 0);
      end
      if (mhalt == 0) repeat (abort_phase) tick();
      state = 1'b0;
      tick();
      chk("stop_busy", int'(busy), 0);
      chk("stop_halted", int'(halted), 0);
      chk("stop_pc", int'(pc), mpc);
      chk("stop_acc", int'(acc), mR);
      chk("stop_zf", int'(zf), mzf);
      chk("stop_cf", int'(cf), mcf);
      mhalt = 0;
   endtask

   function automatic int rnd_word();
      int op, sub;
      op = $urandom_range(0, 9);
      if (op == 9) op = $urandom_range(7, 15);
      if (op == 0) begin
         sub = $urandom_range(0, 10);
         if (sub == 10) sub = 15;
         return ($urandom_range(0, 15) * 16) + sub;
      end
      return op * 256 + $urandom_range(0, 255);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish within the time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int ch, outs0;
      int cd_prog[7]  = '{12'h10A, 12'h201, 12'h002, 12'h006, 12'h008, 12'h402, 12'h00F};
      int cy_prog[7]  = '{12'h1FF, 12'h201, 12'h001, 12'h103, 12'h205, 12'h002, 12'h00F};
      int ab_prog[6]  = '{12'h200, 12'h001, 12'h008, 12'h405, 12'h155, 12'h00F};
      int rs_prog[4]  = '{12'h112, 12'h234, 12'h001, 12'h300};

      rst = 1'b0; state = 1'b0; load = 1'b0; instr = '0;
      tick();
      do_reset();

      // Countdown program
      foreach (cd_prog[i]) do_load(cd_prog[i]);
      outs0 = n_out;
      run(200, 0, ch);
      chk("cd_halt_cycle", ch, 129);
      chk("cd_out_count", n_out - outs0, 10);
      chk("cd_acc", int'(acc), 0);
      chk("cd_zf", int'(zf), 1);
      chk("cd_pc", int'(pc), 6);

      // Carry and borrow
      do_reset();
      foreach (cy_prog[i]) do_load(cy_prog[i]);
      run(3, 1, ch);
      chk("carry_acc", int'(acc), 8'h00);
      chk("carry_zf", int'(zf), 1);
      chk("carry_cf", int'(cf), 1);
      run(20, 0, ch);
      chk("borrow_acc", int'(acc), 8'hFE);
      chk("borrow_cf", int'(cf), 1);
      chk("borrow_zf", int'(zf), 0);

      // Load overflow: the 17th word must not wrap into slot 0
      do_reset();
      for (int i = 0; i < 17; i++) begin
         int w;
         case (i)
            0: w = 12'h133;
            1: w = 12'h200;
            2: w = 12'h001;
            3: w = 12'h008;
            4: w = 12'h00F;
            16: w = 12'h1AA;
            default: w = 0;
         endcase
         do_load(w);
         if (i == 14) chk("pfull_after15", int'(prog_full), 0);
         if (i >= 15) chk("pfull_after16", int'(prog_full), 1);
      end
      outs0 = n_out;
      run(20, 0, ch);
      chk("ovf_out_count", n_out - outs0, 1);
      chk("ovf_acc", int'(acc), 8'h33);

      // PC wrap over an empty (all-NOP) memory
      do_reset();
      run(17, 0, ch);
      chk("wrap_halt", ch, -1);

      // Abort in DECODE of LDA 0x55, then confirm A was not written
      do_reset();
      foreach (ab_prog[i]) do_load(ab_prog[i]);
      run(4, 1, ch);
      run(20, 0, ch);
      run(20, 0, ch);
      chk("abort_final_acc", int'(acc), 8'h55);

      // Reset in the middle of a run; program memory must be cleared too
      do_reset();
      foreach (rs_prog[i]) do_load(rs_prog[i]);
      state = 1'b1;
      repeat (10 + $urandom_range(0, 8)) tick();
      rst = 1'b0;
      tick();
      chk_reset_vals("midrun_rst");
      rst = 1'b1; state = 1'b0;
      m_reset();
      tick();
      run(5, 0, ch);
      chk("cleared_mem_acc", int'(acc), 0);

      // Random programs, two runs each so that register state carries over
      for (int t = 0; t < 8; t++) begin
         do_reset();
         for (int i = 0; i < DEPTH; i++) do_load(rnd_word());
         chk("rnd_pfull", int'(prog_full), 1);
         run($urandom_range(8, 40), $urandom_range(0, 2), ch);
         run($urandom_range(8, 40), $urandom_range(0, 2), ch);
      end

      repeat (3) tick();
      chk("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
